// File: rtl/foc_seq_pkg.sv
// foc_seq shared definitions: opcodes, FSM states, instruction layout.
// Also consumed by the assembler and the execution units.
package foc_seq_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_IN   = 8'h01;
  localparam logic [7:0] OP_OUT  = 8'h02;
  localparam logic [7:0] OP_HALT = 8'h05;
  localparam logic [7:0] OP_BNZ  = 8'h0E;

  localparam logic [7:0] OP_ADD  = 8'h10;
  localparam logic [7:0] OP_SUB  = 8'h11;
  localparam logic [7:0] OP_MUL  = 8'h12;

  // operand bit that routes a/b to the constant ROM
  localparam int CROM_BIT = 7;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_READ_A,
    S_READ_B,
    S_EX_START,
    S_EX_WAIT,
    S_WRITE,
    S_FAULT
  } state_t;

  // op[31:24] a[23:16] b[15:8] q[7:0]
  typedef struct packed {
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
  } instr_t;

  function automatic logic op_internal(input logic [7:0] op);
    return (op == OP_NOP) || (op == OP_IN) ||
           (op == OP_OUT) || (op == OP_HALT) ||
           (op == OP_BNZ);
  endfunction

  function automatic logic op_writes_ram(input logic [7:0] op);
    return (op == OP_IN) || !op_internal(op);
  endfunction

endpackage

// File: rtl/foc_seq_dram.sv
// foc_seq data RAM: one write port, one registered read port.
// Contents are not reset.
module seq_dram
  import foc_seq_pkg::*;
#(
  parameter int DW   = 32,
  parameter int DA_W = 6
) (
  input  logic            c,
  input  logic            we,
  input  logic [DA_W-1:0] waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [DA_W-1:0] raddr,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [2**DA_W];

  // write-first is irrelevant here: reads and writes never share a cycle
  always_ff @(posedge c) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/foc_seq.sv
// foc_seq: microcoded sequencer fetching from a program ROM,
// operands from data RAM or constant ROM, long ops on an external unit.
module foc_seq
  import foc_seq_pkg::*;
#(
  parameter int DW      = 32,
  parameter int PC_W    = 8,
  parameter int DA_W    = 6,
  parameter int N_ENTRY = 4,
  parameter int WDOG    = 1024,
  localparam int ES_W   = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1
) (
  input  logic                    c,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ES_W-1:0]         entry_sel,
  input  logic [N_ENTRY*PC_W-1:0] entry_pc,
  output logic [PC_W-1:0]         prom_addr,
  input  logic [31:0]             prom_q,
  output logic [4:0]              crom_addr,
  input  logic [DW-1:0]           crom_q,
  output logic [7:0]              pin_sel,
  input  logic [DW-1:0]           pin_d,
  output logic                    pout_we,
  output logic [7:0]              pout_sel,
  output logic [DW-1:0]           pout_d,
  output logic                    eu_start,
  output logic [7:0]              eu_op,
  output logic [DW-1:0]           eu_a,
  output logic [DW-1:0]           eu_b,
  input  logic [DW-1:0]           eu_q,
  input  logic                    eu_done,
  output logic                    busy,
  output logic                    done,
  output logic                    fault,
  output logic                    overrun
);

  localparam int WC_W = $clog2(WDOG + 1);

  state_t          state;
  instr_t          ir;
  logic [PC_W-1:0] pc;
  logic [DW-1:0]   reg_a;
  logic [DW-1:0]   reg_b;
  logic [DW-1:0]   res;
  logic            pending;
  logic [ES_W-1:0] pend_sel;
  logic [WC_W-1:0] wcnt;

  logic            ram_we;
  logic [DA_W-1:0] ram_raddr;
  logic [DW-1:0]   ram_q;
  logic [DW-1:0]   a_val;
  logic [DW-1:0]   b_val;
  logic            eu_ack;

  // out-of-range index falls back to entry 0
  function automatic logic [PC_W-1:0] pick_pc(
    input logic [N_ENTRY*PC_W-1:0] tbl,
    input logic [ES_W-1:0]         idx
  );
    logic [PC_W-1:0] r;
    r = tbl[PC_W-1:0];
    for (int i = 1; i < N_ENTRY; i++)
      if (32'(idx) == i) r = tbl[i*PC_W +: PC_W];
    return r;
  endfunction

  assign prom_addr = pc;
  assign pin_sel   = ir.a;
  assign busy      = (state != S_IDLE) && (state != S_FAULT);

  // a is addressed in READ_A, b in READ_B; data returns a cycle later
  assign crom_addr = (state == S_READ_B) ? ir.b[4:0] : ir.a[4:0];
  assign ram_raddr = (state == S_READ_B) ? ir.b[DA_W-1:0]
                                         : ir.a[DA_W-1:0];

  assign a_val = ir.a[CROM_BIT] ? crom_q : ram_q;
  assign b_val = ir.b[CROM_BIT] ? crom_q : ram_q;

  // a done coinciding with our own start pulse is stale
  assign eu_ack = eu_done && !eu_start;

  assign ram_we = (state == S_WRITE) && !rst && op_writes_ram(ir.op);

  seq_dram #(
    .DW   (DW),
    .DA_W (DA_W)
  ) u_dram (
    .c     (c),
    .we    (ram_we),
    .waddr (ir.q[DA_W-1:0]),
    .wdata (res),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  // sequencer FSM with registered strobes and status
  always_ff @(posedge c) begin
    if (rst) begin
      state    <= S_IDLE;
      ir       <= '0;
      pc       <= '0;
      reg_a    <= '0;
      reg_b    <= '0;
      res      <= '0;
      pending  <= 1'b0;
      pend_sel <= '0;
      wcnt     <= '0;
      done     <= 1'b0;
      fault    <= 1'b0;
      overrun  <= 1'b0;
      pout_we  <= 1'b0;
      pout_sel <= '0;
      pout_d   <= '0;
      eu_start <= 1'b0;
      eu_op    <= '0;
      eu_a     <= '0;
      eu_b     <= '0;
    end else begin
      done     <= 1'b0;
      overrun  <= 1'b0;
      pout_we  <= 1'b0;
      eu_start <= 1'b0;

      if (start && busy) begin
        if (pending) overrun <= 1'b1;
        pending  <= 1'b1;
        pend_sel <= entry_sel;
      end

      unique case (state)
        S_IDLE, S_FAULT: begin
          if (start) begin
            pc    <= pick_pc(entry_pc, entry_sel);
            fault <= 1'b0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          pc    <= pc + 1'b1;
          state <= S_DECODE;
        end
        S_DECODE: begin
          ir    <= instr_t'(prom_q);
          state <= S_READ_A;
        end
        S_READ_A: state <= S_READ_B;
        S_READ_B: begin
          reg_a <= a_val;
          state <= S_EX_START;
        end
        S_EX_START: begin
          reg_b <= b_val;
          wcnt  <= '0;
          if (!op_internal(ir.op)) begin
            eu_start <= 1'b1;
            eu_op    <= ir.op;
            eu_a     <= reg_a;
            eu_b     <= b_val;
          end
          state <= S_EX_WAIT;
        end
        S_EX_WAIT: begin
          if (op_internal(ir.op)) begin
            res <= pin_d;
            if (ir.op == OP_OUT) begin
              pout_we  <= 1'b1;
              pout_sel <= ir.a;
              pout_d   <= reg_b;
            end
            state <= S_WRITE;
          end else if (eu_ack) begin
            res   <= eu_q;
            state <= S_WRITE;
          end else if (wcnt == WC_W'(WDOG - 1)) begin
            fault   <= 1'b1;
            pending <= 1'b0;
            state   <= S_FAULT;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_WRITE: begin
          state <= S_FETCH;
          if (ir.op == OP_BNZ && reg_a != '0)
            pc <= PC_W'(ir.q);
          if (ir.op == OP_HALT) begin
            done    <= 1'b1;
            pending <= 1'b0;
            if (start || pending)
              pc <= pick_pc(entry_pc,
                            start ? entry_sel : pend_sel);
            else
              state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_foc_seq.sv
// foc_seq bench: ROM/port/EU models, vector table, scoreboard
// of output-port writes, and hand-built multi-cycle sequences.
module tb_foc_seq;
  import foc_seq_pkg::*;

  logic        c;
  logic        rst;
  logic        start;
  logic [1:0]  entry_sel;
  logic [31:0] entry_pc;
  logic [7:0]  prom_addr;
  logic [31:0] prom_q;
  logic [4:0]  crom_addr;
  logic [31:0] crom_q;
  logic [7:0]  pin_sel;
  logic [31:0] pin_d;
  logic        pout_we;
  logic [7:0]  pout_sel;
  logic [31:0] pout_d;
  logic        eu_start;
  logic [7:0]  eu_op;
  logic [31:0] eu_a;
  logic [31:0] eu_b;
  logic [31:0] eu_q;
  logic        eu_done;
  logic        busy;
  logic        done;
  logic        fault;
  logic        overrun;

  foc_seq #(.WDOG(16)) dut (
    .c(c), .rst(rst), .start(start),
    .entry_sel(entry_sel), .entry_pc(entry_pc),
    .prom_addr(prom_addr), .prom_q(prom_q),
    .crom_addr(crom_addr), .crom_q(crom_q),
    .pin_sel(pin_sel), .pin_d(pin_d),
    .pout_we(pout_we), .pout_sel(pout_sel),
    .pout_d(pout_d),
    .eu_start(eu_start), .eu_op(eu_op),
    .eu_a(eu_a), .eu_b(eu_b),
    .eu_q(eu_q), .eu_done(eu_done),
    .busy(busy), .done(done),
    .fault(fault), .overrun(overrun)
  );

  typedef struct {
    logic [7:0]  sel;
    logic [31:0] d;
  } pout_t;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] res;
    int          cyc;
  } vec_t;

  logic [31:0] prom [256];
  logic [31:0] crom [32];
  pout_t       exp_q [$];
  vec_t        vt [8];

  int n_cmp  = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_ovr  = 0;
  int done_cyc = 5;
  bit eu_hold  = 0;

  initial begin
    c = 0;
    forever #5 c = ~c;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  always @(posedge c) begin
    prom_q <= prom[prom_addr];
    crom_q <= crom[crom_addr];
  end

  assign pin_d = (pin_sel == 8'h03) ? 32'h1234 : {24'h0, pin_sel};

  function automatic logic [31:0] eu_calc(
    input logic [7:0] op, input logic [31:0] a, input logic [31:0] b
  );
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_MUL:  return a * b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // execution unit: done appears in EX_WAIT cycle number done_cyc
  initial begin
    eu_done = 0;
    eu_q = '0;
    forever begin
      @(posedge c); #1;
      if (eu_start && !eu_hold) begin
        repeat (done_cyc - 1) @(posedge c);
        #1;
        eu_q = eu_calc(eu_op, eu_a, eu_b);
        eu_done = 1;
        @(posedge c); #1;
        eu_done = 0;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // scoreboard: every port write must match the next expected one
  always @(negedge c) begin
    pout_t e;
    if (done === 1'b1) n_done++;
    if (overrun === 1'b1) n_ovr++;
    if (pout_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL pout_unexpected: got sel %0h data %0h",
                 pout_sel, pout_d);
      end else begin
        e = exp_q.pop_front();
        chk("pout_sel", 64'(pout_sel), 64'(e.sel));
        chk("pout_d", 64'(pout_d), 64'(e.d));
      end
    end
  end

  function automatic logic [31:0] ins(
    input logic [7:0] op, input logic [7:0] a,
    input logic [7:0] b, input logic [7:0] q
  );
    return {op, a, b, q};
  endfunction

  // start at cycle 0; FETCH is cycle 1. Optional extra starts at
  // cycles at1/at2. Ends once idle after all extra starts.
  task automatic run(input int sel, input int max,
                     input int at1, input int s1,
                     input int at2, input int s2,
                     output int t_done, output int t_fault,
                     output logic f1);
    bit fin;
    fin = 0;
    t_done = 0;
    t_fault = 0;
    f1 = 1'bx;
    @(posedge c); #1;
    start = 1;
    entry_sel = 2'(sel);
    @(posedge c); #1;
    start = 0;
    for (int k = 1; k <= max && !fin; k++) begin
      @(negedge c);
      if (k == 1) f1 = fault;
      if (done === 1'b1) t_done = k;
      if (fault === 1'b1 && t_fault == 0) t_fault = k;
      if (busy === 1'b0 && k > at1 && k > at2) fin = 1;
      @(posedge c); #1;
      start = (k + 1 == at1) || (k + 1 == at2);
      entry_sel = (k + 1 == at2) ? 2'(s2) : 2'(s1);
    end
    start = 0;
    if (!fin) begin
      n_cmp++;
      n_fail++;
      $display("FAIL run_timeout: got busy after %0d want idle", max);
    end
  endtask

  int   td;
  int   tf;
  logic f1;
  int   bad;

  initial begin
    rst = 1;
    start = 0;
    entry_sel = 0;
    entry_pc = {8'hA0, 8'h40, 8'h60, 8'h00};
    for (int i = 0; i < 256; i++) prom[i] = ins(OP_HALT, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 32; i++) crom[i] = '0;
    crom[2] = 32'hAAAA;
    crom[3] = 32'd3;
    crom[4] = 32'd1;
    crom[5] = 32'd0;

    prom[8'h40] = ins(OP_IN,   8'h03, 8'h00, 8'h05);
    prom[8'h41] = ins(OP_OUT,  8'h07, 8'h05, 8'h00);
    prom[8'h42] = ins(OP_HALT, 8'h00, 8'h00, 8'h00);
    prom[8'h60] = ins(OP_OUT,  8'h61, 8'h82, 8'h00);
    prom[8'h61] = ins(OP_HALT, 8'h00, 8'h00, 8'h00);
    prom[8'hA0] = ins(OP_ADD,  8'h83, 8'h85, 8'h00);
    prom[8'hA1] = ins(OP_OUT,  8'h30, 8'h00, 8'h00);
    prom[8'hA2] = ins(OP_SUB,  8'h00, 8'h84, 8'h00);
    prom[8'hA3] = ins(OP_BNZ,  8'h00, 8'h00, 8'hA1);
    prom[8'hA4] = ins(OP_HALT, 8'h00, 8'h00, 8'h00);

    vt[0] = '{OP_ADD, 32'd5,        32'd7,        32'd12,         26};
    vt[1] = '{OP_SUB, 32'd10,       32'd3,        32'd7,          26};
    vt[2] = '{OP_SUB, 32'd0,        32'd1,        32'hFFFF_FFFF,  26};
    vt[3] = '{OP_ADD, 32'hFFFF_FFFF, 32'd1,       32'd0,          26};
    vt[4] = '{OP_MUL, 32'h1_0000,   32'h1_0000,   32'd0,          26};
    vt[5] = '{OP_MUL, 32'hFFFF_FFFF, 32'd2,       32'hFFFF_FFFE,  26};
    vt[6] = '{OP_IN,  32'd0,        32'd0,        32'h80,         22};
    vt[7] = '{OP_MUL, 32'd6,        32'd7,        32'd42,         26};

    repeat (3) @(posedge c);
    #1 rst = 0;
    @(negedge c);
    chk("rst_busy",     64'(busy),      64'd0);
    chk("rst_done",     64'(done),      64'd0);
    chk("rst_fault",    64'(fault),     64'd0);
    chk("rst_overrun",  64'(overrun),   64'd0);
    chk("rst_pout_we",  64'(pout_we),   64'd0);
    chk("rst_eu_start", 64'(eu_start),  64'd0);
    chk("rst_pout_d",   64'(pout_d),    64'd0);
    chk("rst_eu_a",     64'(eu_a),      64'd0);
    chk("rst_eu_b",     64'(eu_b),      64'd0);
    chk("rst_pc",       64'(prom_addr), 64'd0);

    // one operation per vector, result read back through OUT
    for (int i = 0; i < 8; i++) begin
      prom[0] = ins(vt[i].op, 8'h80, 8'h81, 8'h10);
      prom[1] = ins(OP_OUT,  8'h20, 8'h10, 8'h00);
      prom[2] = ins(OP_HALT, 8'h00, 8'h00, 8'h00);
      crom[0] = vt[i].x;
      crom[1] = vt[i].y;
      exp_q.push_back('{8'h20, vt[i].res});
      n_done = 0;
      run(0, 200, 0, 0, 0, 0, td, tf, f1);
      chk("vec_cycles",   64'(td), 64'(vt[i].cyc));
      chk("vec_done_cnt", 64'(n_done), 64'd1);
      chk("vec_left",     64'(exp_q.size()), 64'd0);
    end

    // IN -> RAM5 -> OUT via entry 2
    exp_q.push_back('{8'h07, 32'h1234});
    n_done = 0;
    run(2, 200, 0, 0, 0, 0, td, tf, f1);
    chk("io_cycles",   64'(td), 64'd22);
    chk("io_done_cnt", 64'(n_done), 64'd1);
    chk("io_left",     64'(exp_q.size()), 64'd0);

    // BNZ loop counting 3..1
    for (int v = 3; v >= 1; v--) exp_q.push_back('{8'h30, 32'(v)});
    n_done = 0;
    run(3, 400, 0, 0, 0, 0, td, tf, f1);
    chk("loop_cycles",   64'(td), 64'd94);
    chk("loop_done_cnt", 64'(n_done), 64'd1);
    chk("loop_left",     64'(exp_q.size()), 64'd0);

    // start exactly in the HALT WRITE cycle chains entry 1
    exp_q.push_back('{8'h07, 32'h1234});
    exp_q.push_back('{8'h61, 32'hAAAA});
    n_done = 0;
    n_ovr = 0;
    run(2, 200, 21, 1, 0, 0, td, tf, f1);
    chk("chain_last_done", 64'(td), 64'd36);
    chk("chain_done_cnt",  64'(n_done), 64'd2);
    chk("chain_overrun",   64'(n_ovr), 64'd0);
    chk("chain_left",      64'(exp_q.size()), 64'd0);

    // two starts during a run: second overwrites, raises overrun
    for (int v = 3; v >= 1; v--) exp_q.push_back('{8'h30, 32'(v)});
    exp_q.push_back('{8'h07, 32'h1234});
    n_done = 0;
    n_ovr = 0;
    run(3, 400, 10, 1, 20, 2, td, tf, f1);
    chk("ovr_last_done", 64'(td), 64'd115);
    chk("ovr_done_cnt",  64'(n_done), 64'd2);
    chk("ovr_pulses",    64'(n_ovr), 64'd1);
    chk("ovr_left",      64'(exp_q.size()), 64'd0);

    // watchdog: withheld eu_done, pending request is dropped
    eu_hold = 1;
    n_done = 0;
    run(3, 100, 10, 2, 0, 0, td, tf, f1);
    chk("wd_fault_cycle", 64'(tf), 64'd22);
    chk("wd_no_done",     64'(n_done), 64'd0);
    bad = 0;
    repeat (10) begin
      @(negedge c);
      if (busy !== 1'b0 || fault !== 1'b1) bad++;
    end
    chk("wd_stays_fault", 64'(bad), 64'd0);
    eu_hold = 0;
    exp_q.push_back('{8'h07, 32'h1234});
    run(2, 200, 0, 0, 0, 0, td, tf, f1);
    chk("wd_fault_clear", 64'(f1), 64'd0);
    chk("wd_rerun_done",  64'(td), 64'd22);
    chk("wd_left",        64'(exp_q.size()), 64'd0);

    // reset in the EX_WAIT cycle that sees eu_done: no write, no done
    prom[0] = ins(OP_MUL,  8'h80, 8'h81, 8'h10);
    prom[1] = ins(OP_HALT, 8'h00, 8'h00, 8'h00);
    crom[0] = 32'd3;
    crom[1] = 32'd5;
    done_cyc = 2;
    n_done = 0;
    @(posedge c); #1;
    start = 1;
    entry_sel = 0;
    @(posedge c); #1;
    start = 0;
    repeat (6) @(posedge c);
    #1 rst = 1;
    @(posedge c); #1;
    rst = 0;
    @(negedge c);
    chk("rstrun_busy", 64'(busy), 64'd0);
    chk("rstrun_pc",   64'(prom_addr), 64'd0);
    repeat (6) @(negedge c);
    chk("rstrun_no_done", 64'(n_done), 64'd0);
    done_cyc = 5;
    prom[0] = ins(OP_OUT,  8'h22, 8'h10, 8'h00);
    exp_q.push_back('{8'h22, 32'd42});
    run(0, 200, 0, 0, 0, 0, td, tf, f1);
    chk("rstrun_readback_done", 64'(td), 64'd15);
    chk("rstrun_left", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/foc_seq.md
FOC_SEQ -- requirements
Module: foc_seq

Interface
REQ-001 Parameter DW, 32, datapath/operand width.
REQ-002 Parameter PC_W, 8, program-counter width.
REQ-003 Parameter DA_W, 6, data-RAM address width (2^DA_W words).
REQ-004 Parameter N_ENTRY, 4, number of selectable program entry points.
REQ-005 Parameter WDOG, 1024, max EX_WAIT cycles before fault.
REQ-006 Ports SHALL be:
  c  in  1  clock; one clock, all logic on rising edge
  rst  in  1  reset, synchronous, active-high
  start  in  1  run request pulse
  entry_sel  in  clog2(N_ENTRY)  entry-point index
  entry_pc  in  N_ENTRY*PC_W  flattened entry table
  prom_addr  out  PC_W  program ROM address
  prom_q  in  32  instruction, valid 1 cycle after prom_addr
  crom_addr  out  5  constant ROM address
  crom_q  in  DW  constant, valid 1 cycle after crom_addr
  pin_sel  out  8  input-port select (= operand a)
  pin_d  in  DW  input-port data, combinational from pin_sel
  pout_we  out  1  output-port write strobe
  pout_sel  out  8  output-port select
  pout_d  out  DW  output-port data
  eu_start, eu_op, eu_a, eu_b  out  1/8/DW/DW  execution-unit request
  eu_q, eu_done  in  DW/1  execution-unit result and done pulse
  busy, done, fault, overrun  out  1 each  status

Function
REQ-010 Instruction: op[31:24], a[23:16], b[15:8], q[7:0]; operand bit7=1 selects crom[4:0], else data RAM [DA_W-1:0].
REQ-011 States: IDLE, FETCH, DECODE, READ_A, READ_B, EX_START, EX_WAIT, WRITE, FAULT.
REQ-012 IDLE/FAULT + start: pc <= entry_pc[entry_sel], fault <= 0, go FETCH; entry_sel >= N_ENTRY selects entry 0.
REQ-013 FETCH presents pc, pc <= pc+1 (wraps mod 2^PC_W); DECODE latches prom_q; READ_A presents a; READ_B latches reg_a, presents b; EX_START latches reg_b.
REQ-014 Internal ops: NOP 0x00, IN 0x01, OUT 0x02, HALT 0x05, BNZ 0x0E; they complete in their first EX_WAIT cycle; all other ops are external.
REQ-015 External ops: eu_start one-cycle pulse in cycle after EX_START with eu_op/eu_a/eu_b stable until eu_done; eu_done before eu_start ignored.
REQ-016 WRITE: IN writes pin_d, external ops write eu_q, to RAM[q]; OUT pulses pout_we with pout_sel=a, pout_d=reg_b; NOP/OUT/HALT/BNZ write no RAM.
REQ-017 BNZ: reg_a != 0 loads pc <= q[PC_W-1:0] in WRITE, else falls through.
REQ-018 Minimum instruction latency 7 cycles (FETCH..WRITE).
REQ-019 HALT WRITE: done pulses one cycle next cycle; go IDLE, or FETCH from pending entry if pending set.
REQ-020 start while busy: pending <= 1, pending entry <= entry_sel; start while pending already set overwrites entry, pulses overrun one cycle.
REQ-021 EX_WAIT counter reaching WDOG without eu_done: go FAULT, fault=1 sticky, pending cleared, no RAM write.
REQ-022 start coincident with HALT WRITE: the new request becomes pending and is executed directly after.
REQ-023 busy = 1 in every state except IDLE and FAULT.

Reset
REQ-030 rst: state IDLE, pc 0, pending 0, all strobes/status 0, pout_d/eu_a/eu_b 0; RAM contents undefined; rst mid-run aborts without RAM write or done.

Structure
REQ-040 Opcode constants, state encoding and operand-field positions SHALL live in package foc_seq_pkg, shared with assembler and execution units.
REQ-041 Data RAM SHALL be sub-module seq_dram (1 write, 1 read port, registered read, DA_W x DW).

Verification
REQ-050 entry_pc[2]=0x40, program at 0x40: IN a=3 -> RAM5, OUT a=0x07 b=RAM5, HALT; pin_d=0x1234 -> pout_we sel 0x07 data 0x1234, done once.
REQ-051 External MUL with eu_done 5 cycles after eu_start -> eu_q in RAM[q], instruction time 11 cycles.
REQ-052 Loop: counter=3 via BNZ and external SUB -> body executed 3 times, then HALT, done.
REQ-053 eu_done withheld, WDOG=16 -> fault=1 after 16 EX_WAIT cycles, busy=0; next start clears fault.
REQ-054 Two starts during run (entry 1, then 2) -> overrun pulse, entry 2 runs right after first HALT, two done pulses.
REQ-055 rst asserted mid EX_WAIT -> IDLE next cycle, no done, no write.
